fp32_recip_div_pipe: RTL and testbench
======================================

# fp32_recip_div_pipe

Parametrised, fully pipelined IEEE-754 single-precision divider for the softmax datapath. It computes a/b as a × LUT(1/mantissa_b) × 2^-(exp_b-127). Compared with the earlier strobe-based divider it adds:

- a configurable reciprocal-LUT index width;
- valid/ready back-pressure with a pass-through tag;
- full special-case handling: zero, inf, NaN, denormal, exponent overflow/underflow.

It sits between the exponent-sum accumulator and the softmax output normaliser.

## Interface
- LUT_BITS, 3, divisor-mantissa MSBs used as reciprocal LUT index; legal 1..8
- TAG_W, 4, width of sideband tag carried alongside each operation
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_a  input  32  dividend (fp32)
- in_b  input  32  divisor (fp32)
- in_tag  input  TAG_W  sideband, returned unchanged with result
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- out_z  output  32  quotient (fp32)
- out_tag  output  TAG_W  tag of this result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_flags  output  4  {invalid, div_by_zero, overflow, underflow}; present only with DIVIDER_FLAGS_EN

## Operation
- **Pipeline structure:** three stages, S1 decode/LUT, S2 multiply, S3 normalise/exponent/special. Each stage has a valid bit.
- **Transfers:** input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- **Stall:** global stall = S3 valid && !out_ready. While stalled, all stage registers hold. in_ready = !stall.
- **Input decode:**
  - exponent 0 (including denormals) is treated as signed zero;
  - exponent 255 with mantissa 0 is inf;
  - exponent 255 with nonzero mantissa is NaN.
- **LUT:**
  - k = in_b[22:23-LUT_BITS];
  - recip[k] = floor(2^(24+LUT_BITS) / (2^LUT_BITS + k)), stored 25-bit Q1.24;
  - LUT is generated at elaboration, not hard-coded.
- **Multiply:** p = {1,a[22:0]} (24b) × recip (25b) = 49b Q2.47.
  - If p[47]: mant = p[46:24], adj = 0.
  - Else: mant = p[45:23], adj = -1.
  - Truncation, no rounding.
- **Exponent:** ez = ea - eb + 127 + adj, computed 10-bit signed.
  - ez ≥ 255: ±inf, overflow.
  - ez ≤ 0: ±0, underflow (flush, no denormal output).
- **Sign:** sign = sa ^ sb for all non-NaN results.
- **Special-case priority:**
  1. Any NaN, 0/0, or inf/inf → 0x7FC00000, invalid.
  2. b zero → ±inf, div_by_zero.
  3. a inf → ±inf.
  4. a zero or b inf → ±0, no flag.
- Tag and flags travel with their operation through every stage.

## Timing
- Latency: result appears on out_valid 3 cycles after input transfer when no stall. Throughput: 1 op/cycle.
- Reset values: out_z = 0, out_tag = 0, out_valid = 0, out_flags = 0, all stage valids = 0.
- in_ready is 1 from the first cycle after rst_n deasserts.
- in_ready depends combinationally on out_ready.
- out_z, out_tag and out_flags are held stable while out_valid && !out_ready.
- Simultaneous output transfer and new input when the pipe is full: both occur. Nothing is dropped or duplicated.
- Bubbles: a cycle with in_valid = 0 propagates as an invalid slot. out_valid never asserts for a bubble.
- Reset mid-operation: all in-flight operations are discarded asynchronously. out_valid falls immediately on rst_n low.

## Configuration
- DIVIDER_FLAGS_EN
  - **Defined:** out_flags port and flag pipeline registers exist. Flags are valid only with out_valid and are 0 otherwise.
  - **Undefined:** port and registers are absent. out_z behaviour is identical.

## Test plan
- LUT_BITS = 3. 0x40C00000 / 0x40000000 (6/2) → out_z = 0x40400000, 3 cycles after accept, out_flags = 0.
- LUT_BITS = 3. 0x3F800000 / 0x40400000 (1/3) → k = 4, recip = 0xAAAAAA, out_z = 0x3EAAAAAA.
- 0x3F800000 / 0x00000000 → 0x7F800000 with div_by_zero. 0x00000000 / 0x80000000 → 0x7FC00000 with invalid. 0xBF800000 / 0x7F800000 → 0x80000000.
- 0x7F000000 / 0x00800000 → 0x7F800000 with overflow. 0x00800000 / 0x7F000000 → 0x00000000 with underflow.
- Back-pressure:
  - stimulus: stream 8 tagged ops (tags 0..7) back-to-back; hold out_ready = 0 for 5 cycles mid-stream;
  - response: in_ready drops while stalled, out_z/out_tag are held stable, all 8 results arrive in order with tags 0..7, no loss or duplicates.
- Reset mid-stream:
  - stimulus: pulse rst_n low with 3 ops in flight;
  - response: out_valid = 0 immediately, no stale result after release, the next op completes normally.

Source files
------------

// File: rtl/fp32_recip_div_pipe.sv
`timescale 1ns/1ps
// fp32_recip_div_pipe
//   Three-stage pipelined IEEE-754 single-precision divider for the softmax
//   datapath. It computes a/b as a * recip(mantissa_b) * 2^-(eb-127). The
//   reciprocal comes from a small LUT indexed by the top LUT_BITS divisor
//   mantissa bits. The mantissa is truncated and not rounded. Denormal
//   inputs are treated as signed zero. Results that overflow become +/-inf.
//   Results that underflow are flushed to +/-0.
//
//   Optional feature macro: DIVIDER_FLAGS_EN
//     When defined, the out_flags port and the flag pipeline registers exist.
//     When undefined, both are absent and out_z behaves identically.
//
// Parameters
//   LUT_BITS  divisor mantissa MSBs used as the LUT index (1..8)
//   TAG_W     width of the sideband tag
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_a       dividend (fp32)
//   in_b       divisor (fp32)
//   in_tag     sideband, returned unchanged with the result
//   in_valid   operands valid
//   in_ready   block accepts operands this cycle
//   out_z      quotient (fp32)
//   out_tag    tag of this result
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_flags  {invalid, div_by_zero, overflow, underflow} (DIVIDER_FLAGS_EN)
//
// Handshake: an input transfer happens on a rising edge where
//   in_valid && in_ready. An output transfer happens on a rising edge where
//   out_valid && out_ready. A producer holds its data stable until the
//   transfer. The pipe stalls as a whole when S3 holds a result that the
//   consumer does not take. In that case every stage register holds and
//   in_ready is low, so in_ready depends combinationally on out_ready.
module fp32_recip_div_pipe #(
  parameter int LUT_BITS = 3,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DIVIDER_FLAGS_EN
  ,
  output logic [3:0]       out_flags
`endif
);

  // Result class decided at decode time. SP_NONE means a normal divide.
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_e;

  localparam int LUT_N = 1 << LUT_BITS;

  // ---------------------------------------------------------------------
  // Reciprocal LUT: recip[k] = floor(2^(24+L) / (2^L + k)), Q1.24.
  // Entry 0 is exactly 1.0 (bit 24), so the table needs 25 bits.
  // ---------------------------------------------------------------------
  logic [24:0] w_lut [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam longint unsigned NUM = 64'd1 << (24 + LUT_BITS);
    localparam longint unsigned DEN = (64'd1 << LUT_BITS) + 64'(gi);
    assign w_lut[gi] = 25'(NUM / DEN);
  end

  logic w_stall;
  logic r_s1_valid, r_s2_valid, r_s3_valid;

  assign w_stall  = r_s3_valid && !out_ready;
  assign in_ready = !w_stall;

  // ---------------------------------------------------------------------
  // S1: decode and LUT lookup
  // ---------------------------------------------------------------------
  logic [7:0]          w_a_exp, w_b_exp;
  logic                w_a_zero, w_a_inf, w_a_nan;
  logic                w_b_zero, w_b_inf, w_b_nan;
  logic [LUT_BITS-1:0] w_idx;
  spec_e               w_spec;

  assign w_a_exp  = in_a[30:23];
  assign w_b_exp  = in_b[30:23];
  assign w_a_zero = (w_a_exp == 8'd0);
  assign w_b_zero = (w_b_exp == 8'd0);
  assign w_a_inf  = (&w_a_exp) && (in_a[22:0] == 23'd0);
  assign w_b_inf  = (&w_b_exp) && (in_b[22:0] == 23'd0);
  assign w_a_nan  = (&w_a_exp) && (in_a[22:0] != 23'd0);
  assign w_b_nan  = (&w_b_exp) && (in_b[22:0] != 23'd0);
  assign w_idx    = in_b[22:23-LUT_BITS];

`ifdef DIVIDER_FLAGS_EN
  logic [3:0] w_s1_flags;
`endif

  // Special-case priority: invalid, then divide-by-zero, then inf/x,
  // then the results that are zero.
  always_comb begin
    w_spec = SP_NONE;
`ifdef DIVIDER_FLAGS_EN
    w_s1_flags = 4'b0000;
`endif
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec = SP_NAN;
`ifdef DIVIDER_FLAGS_EN
      w_s1_flags = 4'b1000;
`endif
    end else if (w_b_zero) begin
      w_spec = SP_INF;
`ifdef DIVIDER_FLAGS_EN
      w_s1_flags = 4'b0100;
`endif
    end else if (w_a_inf) begin
      w_spec = SP_INF;
    end else if (w_a_zero || w_b_inf) begin
      w_spec = SP_ZERO;
    end
  end

  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_sign;
  logic [7:0]       r_s1_ea, r_s1_eb;
  logic [23:0]      r_s1_ma;
  logic [24:0]      r_s1_recip;
  spec_e            r_s1_spec;
`ifdef DIVIDER_FLAGS_EN
  logic [3:0]       r_s1_flags;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_ea    <= 8'd0;
      r_s1_eb    <= 8'd0;
      r_s1_ma    <= 24'd0;
      r_s1_recip <= 25'd0;
      r_s1_spec  <= SP_NONE;
`ifdef DIVIDER_FLAGS_EN
      r_s1_flags <= 4'b0000;
`endif
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s1_tag   <= in_tag;
      r_s1_sign  <= in_a[31] ^ in_b[31];
      r_s1_ea    <= w_a_exp;
      r_s1_eb    <= w_b_exp;
      r_s1_ma    <= {1'b1, in_a[22:0]};
      r_s1_recip <= w_lut[w_idx];
      r_s1_spec  <= w_spec;
`ifdef DIVIDER_FLAGS_EN
      r_s1_flags <= w_s1_flags;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // S2: 24x25 mantissa multiply (Q2.47) and the unadjusted exponent
  // ---------------------------------------------------------------------
  logic [48:0] w_prod;
  logic [9:0]  w_ediff;
  logic        w_unused_prod;

  assign w_prod  = {25'd0, r_s1_ma} * {24'd0, r_s1_recip};
  assign w_ediff = {2'b00, r_s1_ea} - {2'b00, r_s1_eb} + 10'd127;
  // The product is always below 2^48. The bits under p[23] are truncated.
  assign w_unused_prod = ^{w_prod[48], w_prod[22:0]};

  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_sign;
  logic [9:0]       r_s2_exp;
  logic [24:0]      r_s2_prod;   // p[47:23]
  spec_e            r_s2_spec;
`ifdef DIVIDER_FLAGS_EN
  logic [3:0]       r_s2_flags;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_sign  <= 1'b0;
      r_s2_exp   <= 10'd0;
      r_s2_prod  <= 25'd0;
      r_s2_spec  <= SP_NONE;
`ifdef DIVIDER_FLAGS_EN
      r_s2_flags <= 4'b0000;
`endif
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_tag   <= r_s1_tag;
      r_s2_sign  <= r_s1_sign;
      r_s2_exp   <= w_ediff;
      r_s2_prod  <= w_prod[47:23];
      r_s2_spec  <= r_s1_spec;
`ifdef DIVIDER_FLAGS_EN
      r_s2_flags <= r_s1_flags;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // S3: normalise, final exponent, special-case selection
  // ---------------------------------------------------------------------
  logic        w_norm;
  logic [22:0] w_mant;
  logic [9:0]  w_ez;
  logic        w_ovf, w_unf;
  logic [31:0] w_z;

  // If p[47] is clear, the quotient mantissa is below 1.0. Shift left by one
  // and decrement the exponent.
  assign w_norm = r_s2_prod[24];
  assign w_mant = w_norm ? r_s2_prod[23:1] : r_s2_prod[22:0];
  assign w_ez   = r_s2_exp - (w_norm ? 10'd0 : 10'd1);
  assign w_ovf  = ($signed(w_ez) >= 10'sd255);
  assign w_unf  = ($signed(w_ez) <= 10'sd0);

`ifdef DIVIDER_FLAGS_EN
  logic [3:0] w_s3_flags;
`endif

  always_comb begin
    w_z = {r_s2_sign, w_ez[7:0], w_mant};
`ifdef DIVIDER_FLAGS_EN
    w_s3_flags = r_s2_flags;
`endif
    case (r_s2_spec)
      SP_NAN:  w_z = 32'h7FC0_0000;
      SP_INF:  w_z = {r_s2_sign, 8'hFF, 23'd0};
      SP_ZERO: w_z = {r_s2_sign, 31'd0};
      default: begin
        if (w_ovf) begin
          w_z = {r_s2_sign, 8'hFF, 23'd0};
        end else if (w_unf) begin
          w_z = {r_s2_sign, 31'd0};
        end
`ifdef DIVIDER_FLAGS_EN
        w_s3_flags = {2'b00, w_ovf, w_unf};
`endif
      end
    endcase
  end

  logic [31:0]      r_s3_z;
  logic [TAG_W-1:0] r_s3_tag;
`ifdef DIVIDER_FLAGS_EN
  logic [3:0]       r_s3_flags;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_z     <= 32'd0;
      r_s3_tag   <= '0;
`ifdef DIVIDER_FLAGS_EN
      r_s3_flags <= 4'b0000;
`endif
    end else if (!w_stall) begin
      r_s3_valid <= r_s2_valid;
      r_s3_z     <= w_z;
      r_s3_tag   <= r_s2_tag;
`ifdef DIVIDER_FLAGS_EN
      // A bubble carries no flags, so out_flags reads 0 whenever out_valid is 0.
      r_s3_flags <= r_s2_valid ? w_s3_flags : 4'b0000;
`endif
    end
  end

  assign out_valid = r_s3_valid;
  assign out_z     = r_s3_z;
  assign out_tag   = r_s3_tag;
`ifdef DIVIDER_FLAGS_EN
  assign out_flags = r_s3_flags;
`endif

endmodule

// File: tb/tb_fp32_recip_div_pipe.sv
`timescale 1ns/1ps
// tb_fp32_recip_div_pipe
//   Directed-vector bench for fp32_recip_div_pipe with LUT_BITS = 3 and
//   TAG_W = 4. It drives inputs 1 ns after the rising edge. A monitor on the
//   falling edge pops the expected queue on every output transfer. Each queue
//   entry is {flags, tag, z}.
module tb_fp32_recip_div_pipe;

  localparam int TAG_W = 4;
  localparam int QW    = 32 + TAG_W + 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_z;
  logic [TAG_W-1:0] out_tag;
  logic             out_valid;
  logic             out_ready;
`ifdef DIVIDER_FLAGS_EN
  logic [3:0]       out_flags;
`endif

  fp32_recip_div_pipe #(.LUT_BITS(3), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_z     (out_z),
    .out_tag   (out_tag),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DIVIDER_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_rx     = 0;
  logic [QW-1:0] exp_q[$];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        logic [QW-1:0] e;
        e = exp_q.pop_front();
        n_rx++;
        check_eq("out_z", out_z, e[31:0]);
        check_eq("out_tag", 32'(out_tag), 32'(e[35:32]));
`ifdef DIVIDER_FLAGS_EN
        check_eq("out_flags", 32'(out_flags), 32'(e[39:36]));
`endif
      end
    end
  end

  // Driver: present one operation, wait (bounded) for in_ready just before
  // the edge, and optionally record the expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input logic [31:0] z, input logic [3:0] fl, input bit track);
    int budget = 0;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    if (track) exp_q.push_back({fl, tag, z});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 64) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Directed vectors with hand-computed results (flags {inv,dbz,ovf,unf}).
  localparam int NV = 16;
  logic [31:0] vec_a [NV] = '{
    32'h3F800000, 32'h3F800000, 32'h00000000, 32'hBF800000,
    32'h7F000000, 32'h00800000, 32'h40400000, 32'h7FC00001,
    32'h7F800000, 32'hFF800000, 32'hC0C00000, 32'h00000001,
    32'h3F800000, 32'h7F800000, 32'h7F000000, 32'h00800000};
  logic [31:0] vec_b [NV] = '{
    32'h40400000, 32'h00000000, 32'h80000000, 32'h7F800000,
    32'h00800000, 32'h7F000000, 32'h3FC00000, 32'h3F800000,
    32'hFF800000, 32'h40000000, 32'h40000000, 32'h3F800000,
    32'h80000010, 32'h00000000, 32'h3F800000, 32'h3FC00000};
  logic [31:0] vec_z [NV] = '{
    32'h3EAAAAAA, 32'h7F800000, 32'h7FC00000, 32'h80000000,
    32'h7F800000, 32'h00000000, 32'h3FFFFFFF, 32'h7FC00000,
    32'h7FC00000, 32'hFF800000, 32'hC0400000, 32'h00000000,
    32'hFF800000, 32'h7F800000, 32'h7F000000, 32'h00000000};
  logic [3:0]  vec_f [NV] = '{
    4'h0, 4'h4, 4'h8, 4'h0,
    4'h2, 4'h1, 4'h0, 4'h8,
    4'h8, 4'h0, 4'h0, 4'h0,
    4'h4, 4'h4, 4'h0, 4'h1};

  int rx_before;

  initial begin
    rst_n     = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_tag    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_z", out_z, 32'd0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);
`ifdef DIVIDER_FLAGS_EN
    check_eq("rst_out_flags", 32'(out_flags), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);

    // 6/2 with a latency check: S1, S2, then valid in S3
    send(32'h40C00000, 32'h40000000, 4'h0, 32'h40400000, 4'h0, 1'b1);
    check_eq("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_cycle2_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_cycle3_valid", 32'(out_valid), 32'd1);
    drain();

    // directed special cases and boundaries, back to back
    for (int i = 0; i < NV; i++) begin
      send(vec_a[i], vec_b[i], 4'(i), vec_z[i], vec_f[i], 1'b1);
    end
    drain();

    // back-pressure: 8 tagged ops, out_ready low for 5 cycles mid-stream
    rx_before = n_rx;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i % 2 == 0)
            send(32'h41000000 | (32'(i) << 12), 32'h40000000, 4'(i),
                 32'h40800000 | (32'(i) << 12), 4'h0, 1'b1);
          else
            send(32'h41000000 | (32'(i) << 12), 32'h40800000, 4'(i),
                 32'h40000000 | (32'(i) << 12), 4'h0, 1'b1);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check_eq("stall_in_ready", 32'(in_ready), 32'd0);
          check_eq("stall_out_valid", 32'(out_valid), 32'd1);
          if (exp_q.size() > 0) begin
            check_eq("stall_hold_z", out_z, exp_q[0][31:0]);
            check_eq("stall_hold_tag", 32'(out_tag), 32'(exp_q[0][35:32]));
          end
          @(posedge clk);
          #2;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_result_count", 32'(n_rx - rx_before), 32'd8);

    // reset with 3 ops in flight
    for (int i = 0; i < 3; i++) begin
      send(32'h40C00000, 32'h40000000, 4'(10 + i), 32'h40400000, 4'h0, 1'b0);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_z", out_z, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    rx_before = n_rx;
    repeat (6) @(posedge clk);
    #1;
    check_eq("midrst_no_stale", 32'(n_rx - rx_before), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    send(32'h3F800000, 32'h3F800000, 4'h9, 32'h3F800000, 4'h0, 1'b1);
    drain();
    check_eq("midrst_next_op", 32'(n_rx - rx_before), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
